sifre_cozucu: RTL and testbench

SIFRE_COZUCU -- requirements
Module: sifre_cozucu

---
 rtl/sifre_cozucu.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sifre_cozucu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sifre_cozucu.sv
`default_nettype none
// ============================================================================
// Module   : sifre_cozucu_sbox
// Purpose  : AES byte substitution. INVERSE=0 gives the forward S-box,
//            INVERSE=1 gives the inverse S-box. Both are computed as the
//            GF(2^8) multiplicative inverse combined with the AES affine map,
//            so no 256-entry tables are needed.
// Ports    : a_i  - input byte
//            y_o  - substituted byte
// Revision : 1.0  initial release
// ============================================================================
module sifre_cozucu_sbox #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Multiplication modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    generate
        if (INVERSE) begin : g_inv
            logic [7:0] w_b;
            // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then invert.
            assign w_b = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]}
                       ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
            assign y_o = gf_inv(w_b);
        end else begin : g_fwd
            logic [7:0] w_b;
            // Invert, then affine map: b ^ rotl1..rotl4 ^ 0x63.
            assign w_b = gf_inv(a_i);
            assign y_o = w_b ^ {w_b[6:0], w_b[7]} ^ {w_b[5:0], w_b[7:6]}
                       ^ {w_b[4:0], w_b[7:5]} ^ {w_b[3:0], w_b[7:4]} ^ 8'h63;
        end
    endgenerate

endmodule

// ============================================================================
// Module   : sifre_cozucu
// Purpose  : Iterative AES-128 inverse cipher, one round per clock.
//            The key register is first expanded forward to K10, then walked
//            back one round key per cycle alongside the decryption rounds.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            anahtar    - 128-bit cipher key (bit 127 = byte 0 MSB)
//            sifre      - 128-bit ciphertext block
//            g_gecerli  - request valid (accepted when hazir=1)
//            hazir      - ready, high only while idle
//            blok       - recovered plaintext, held until next result
//            c_gecerli  - one-cycle result-valid pulse
// Timing   : accept at E0, c_gecerli between E21 and E22, idle after E22.
// Revision : 1.0  initial release
// ============================================================================
module sifre_cozucu (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,
        GENISLET = 3'd1,
        ILK_EKLE = 3'd2,
        TUR      = 3'd3,
        BITTI    = 3'd4
    } durum_t;

    durum_t       durum_q, durum_d;
    logic [127:0] anahtar_q, anahtar_d;
    logic [127:0] veri_q, veri_d;
    logic [127:0] blok_q, blok_d;
    logic [3:0]   sayac_q, sayac_d;
    logic         c_gecerli_q, c_gecerli_d;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // ------------------------------------------------------------------
    // Key schedule (forward and inverse share the four forward S-boxes)
    // ------------------------------------------------------------------
    logic [31:0] w_k0, w_k1, w_k2, w_k3;
    logic [31:0] w_sub_in, w_rot, w_sub, w_rcon;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;
    logic [31:0] w_i0, w_i1, w_i2, w_i3;

    assign w_k0 = anahtar_q[127:96];
    assign w_k1 = anahtar_q[95:64];
    assign w_k2 = anahtar_q[63:32];
    assign w_k3 = anahtar_q[31:0];

    // Walking backwards, the previous key's last word is w3^w2, which is
    // what the SubWord/RotWord term is built from.
    assign w_sub_in = (durum_q == TUR) ? (w_k3 ^ w_k2) : w_k3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_rcon   = {rcon(sayac_q), 24'h000000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ksb
            sifre_cozucu_sbox #(.INVERSE(1'b0)) u_sbox (
                .a_i (w_rot[31-8*gi -: 8]),
                .y_o (w_sub[31-8*gi -: 8])
            );
        end
    endgenerate

    assign w_f0 = w_k0 ^ w_sub ^ w_rcon;
    assign w_f1 = w_k1 ^ w_f0;
    assign w_f2 = w_k2 ^ w_f1;
    assign w_f3 = w_k3 ^ w_f2;

    assign w_i3 = w_k3 ^ w_k2;
    assign w_i2 = w_k2 ^ w_k1;
    assign w_i1 = w_k1 ^ w_k0;
    assign w_i0 = w_k0 ^ w_sub ^ w_rcon;

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    // Byte i of the state is row i%4, column i/4.
    // ------------------------------------------------------------------
    logic [127:0] w_sb, w_ark, w_imc;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_isb
            // Row r is rotated right by r: out[r][c] = in[r][(c-r) mod 4].
            localparam int C_SRC = 4 * (((gi / 4) - (gi % 4) + 4) % 4) + (gi % 4);
            sifre_cozucu_sbox #(.INVERSE(1'b1)) u_isbox (
                .a_i (veri_q[127-8*C_SRC -: 8]),
                .y_o (w_sb[127-8*gi -: 8])
            );
        end
    endgenerate

    assign w_ark = w_sb ^ {w_i0, w_i1, w_i2, w_i3};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_imc
            assign w_imc[127-32*gi -: 32] = inv_mix_col(w_ark[127-32*gi -: 32]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        durum_d     = durum_q;
        anahtar_d   = anahtar_q;
        veri_d      = veri_q;
        sayac_d     = sayac_q;
        blok_d      = blok_q;
        c_gecerli_d = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (g_gecerli) begin
                    anahtar_d = anahtar;
                    veri_d    = sifre;
                    sayac_d   = 4'd1;
                    durum_d   = GENISLET;
                end
            end
            GENISLET: begin
                anahtar_d = {w_f0, w_f1, w_f2, w_f3};
                sayac_d   = sayac_q + 4'd1;
                if (sayac_q == 4'd10) durum_d = ILK_EKLE;
            end
            ILK_EKLE: begin
                veri_d  = veri_q ^ anahtar_q;
                sayac_d = 4'd10;
                durum_d = TUR;
            end
            TUR: begin
                anahtar_d = {w_i0, w_i1, w_i2, w_i3};
                sayac_d   = sayac_q - 4'd1;
                if (sayac_q == 4'd1) begin
                    // Final round has no InvMixColumns; publish the result.
                    veri_d      = w_ark;
                    blok_d      = w_ark;
                    c_gecerli_d = 1'b1;
                    durum_d     = BITTI;
                end else begin
                    veri_d = w_imc;
                end
            end
            BITTI: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q     <= BOSTA;
            anahtar_q   <= 128'h0;
            veri_q      <= 128'h0;
            blok_q      <= 128'h0;
            sayac_q     <= 4'd0;
            c_gecerli_q <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            anahtar_q   <= anahtar_d;
            veri_q      <= veri_d;
            blok_q      <= blok_d;
            sayac_q     <= sayac_d;
            c_gecerli_q <= c_gecerli_d;
        end
    end

    assign hazir     = (durum_q == BOSTA);
    assign blok      = blok_q;
    assign c_gecerli = c_gecerli_q;

endmodule
`default_nettype wire

// File: tb/tb_sifre_cozucu.sv
`default_nettype none
// ============================================================================
// Module   : tb_sifre_cozucu
// Purpose  : Scoreboard testbench for sifre_cozucu using known AES-128
//            vectors. The driver pushes expected plaintext and the expected
//            pulse cycle; an independent monitor checks every c_gecerli pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_sifre_cozucu;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] anahtar = 128'h0;
    logic [127:0] sifre = 128'h0;
    logic         g_gecerli = 1'b0;
    logic         hazir;
    logic [127:0] blok;
    logic         c_gecerli;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [127:0] exp_q[$];
    int           lat_q[$];

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_C   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_P   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KF_K  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] KF_C  = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] KF_P  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] Z_C   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] SP_C  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] SP_P  = 128'h6bc1bee22e409f96e93d7e117393172a;

    sifre_cozucu dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .sifre     (sifre),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .blok      (blok),
        .c_gecerli (c_gecerli)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one request. hold keeps g_gecerli high after acceptance;
    // expect_out=0 is used for an operation that will be aborted.
    task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                        input bit hold, input bit expect_out);
        int n;
        n = 0;
        @(negedge clk);
        while (hazir !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (hazir !== 1'b1) begin
            checks++;
            $display("FAIL hazir_timeout: hazir=%b expected 1", hazir);
            return;
        end
        anahtar   = k;
        sifre     = c;
        g_gecerli = 1'b1;
        if (expect_out) begin
            exp_q.push_back(p);
            lat_q.push_back(cyc + 1 + 21);
        end
        @(posedge clk);
        #1;
        if (!hold) g_gecerli = 1'b0;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    initial begin
        logic [127:0] e;
        int           l;
        forever begin
            @(negedge clk);
            if (c_gecerli === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pulse: c_gecerli=1 with no request pending, blok=%h", blok);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    chk("blok", blok, e);
                    chk("latency_cycle", 128'(cyc), 128'(l));
                    chk("hazir_during_pulse", {127'h0, hazir}, 128'h0);
                    @(negedge clk);
                    chk("pulse_one_cycle", {127'h0, c_gecerli}, 128'h0);
                    chk("hazir_after_pulse", {127'h0, hazir}, 128'h1);
                    chk("blok_held", blok, e);
                end
            end
        end
    end

    initial begin
        bit busy_bad;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hazir", {127'h0, hazir}, 128'h1);
        chk("rst_c_gecerli", {127'h0, c_gecerli}, 128'h0);
        chk("rst_blok", blok, 128'h0);
        rst = 1'b0;

        // Known-answer vectors
        send(C1_K, C1_C, C1_P, 1'b0, 1'b1);
        send(B_K, B_C, B_P, 1'b0, 1'b1);
        send(128'h0, Z_C, 128'h0, 1'b0, 1'b1);
        send(B_K, SP_C, SP_P, 1'b0, 1'b1);

        // Back-to-back with g_gecerli held high
        send(KF_K, KF_C, KF_P, 1'b1, 1'b1);
        send(C1_K, C1_C, C1_P, 1'b0, 1'b1);

        // Inputs toggled while busy must be ignored
        send(C1_K, C1_C, C1_P, 1'b0, 1'b1);
        busy_bad = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 3; i <= 15; i++) begin
            anahtar   = {$urandom, $urandom, $urandom, $urandom};
            sifre     = {$urandom, $urandom, $urandom, $urandom};
            g_gecerli = 1'b1;
            @(negedge clk);
            if (hazir !== 1'b0) busy_bad = 1'b1;
        end
        g_gecerli = 1'b0;
        chk("busy_hazir_low", {127'h0, busy_bad}, 128'h0);

        // Asynchronous reset in the middle of an operation
        send(C1_K, C1_C, C1_P, 1'b0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_hazir", {127'h0, hazir}, 128'h1);
        chk("abort_c_gecerli", {127'h0, c_gecerli}, 128'h0);
        chk("abort_blok", blok, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        send(C1_K, C1_C, C1_P, 1'b0, 1'b1);

        // Drain outstanding expectations
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
